fft_butterfly_core: RTL and testbench

Pipelined radix-2 decimation-in-time butterfly for the parallel FFT datapath. It sits directly downstream of the AXI4-Lite register/loader stage. Each accepted transfer carries two complex samples `a` and `b` and one twiddle `w`. The block produces `x = a + w·b` and `y = a − w·b` in fixed point, with optional divide-by-2 scaling and saturation. Several instances run side by side, one per butterfly lane, and each lane has its own valid/ready stream.

---
 rtl/fft_butterfly_core.sv | 124 ++++++++++++
 tb/tb_fft_butterfly_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_core.sv
// Radix-2 DIT butterfly x = a + w*b, y = a - w*b with optional /2 rounding and saturation.
// Three register stages, three cycles of latency; a stalled output freezes every stage and drops in_ready.
module fft_butterfly_core #(
   parameter int DATA_W = 16,
   parameter int TW_W   = 16,
   parameter int SCALE  = 1,
   parameter int TAG_W  = 8
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_a_re,
   input  logic signed [DATA_W-1:0] in_a_im,
   input  logic signed [DATA_W-1:0] in_b_re,
   input  logic signed [DATA_W-1:0] in_b_im,
   input  logic signed [TW_W-1:0]   in_w_re,
   input  logic signed [TW_W-1:0]   in_w_im,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_x_re,
   output logic signed [DATA_W-1:0] out_x_im,
   output logic signed [DATA_W-1:0] out_y_re,
   output logic signed [DATA_W-1:0] out_y_im,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     ovf,
   input  logic                     ovf_clr
);
   localparam int PW = DATA_W + TW_W;
   localparam int SW = DATA_W + 2;
   localparam logic signed [PW:0]   TW_RND = {{(PW-TW_W+2){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
   localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (DATA_W-1)) - 1);
   localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

   logic en;
   logic s1_valid, s2_valid, s3_valid;
   logic signed [DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
   logic signed [TW_W-1:0]   s1_w_re, s1_w_im;
   logic [TAG_W-1:0]         s1_tag, s2_tag, s3_tag;
   logic signed [PW-1:0]     s2_p_rr, s2_p_ii, s2_p_ri, s2_p_ir;
   logic signed [DATA_W-1:0] s2_a_re, s2_a_im;
   logic signed [DATA_W-1:0] s3_x_re, s3_x_im, s3_y_re, s3_y_im;

   logic signed [PW:0]   tr_full, ti_full;
   logic signed [SW-1:0] tr, ti, a_re_ext, a_im_ext;
   logic [DATA_W:0]      x_re_f, x_im_f, y_re_f, y_im_f;
   logic                 any_sat;

   // Returns {saturated, value} after optional round-half-up halving.
   function automatic logic [DATA_W:0] scale_sat(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] v;
      v = (SCALE != 0) ? ((s + SW'(1)) >>> 1) : s;
      if (v > SAT_HI)      scale_sat = {1'b1, SAT_HI[DATA_W-1:0]};
      else if (v < SAT_LO) scale_sat = {1'b1, SAT_LO[DATA_W-1:0]};
      else                 scale_sat = {1'b0, v[DATA_W-1:0]};
   endfunction

   assign en       = !s3_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      tr_full  = (PW+1)'(s2_p_rr) - (PW+1)'(s2_p_ii) + TW_RND;
      ti_full  = (PW+1)'(s2_p_ri) + (PW+1)'(s2_p_ir) + TW_RND;
      tr       = SW'(tr_full >>> (TW_W-1));
      ti       = SW'(ti_full >>> (TW_W-1));
      a_re_ext = SW'(s2_a_re);
      a_im_ext = SW'(s2_a_im);
      x_re_f   = scale_sat(a_re_ext + tr);
      x_im_f   = scale_sat(a_im_ext + ti);
      y_re_f   = scale_sat(a_re_ext - tr);
      y_im_f   = scale_sat(a_im_ext - ti);
      any_sat  = x_re_f[DATA_W] | x_im_f[DATA_W] | y_re_f[DATA_W] | y_im_f[DATA_W];
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (en) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
         end
         // A saturating load takes priority over a simultaneous clear.
         if (en && s2_valid && any_sat) ovf <= 1'b1;
         else if (ovf_clr)              ovf <= 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (en) begin
         s1_a_re <= in_a_re;
         s1_a_im <= in_a_im;
         s1_b_re <= in_b_re;
         s1_b_im <= in_b_im;
         s1_w_re <= in_w_re;
         s1_w_im <= in_w_im;
         s1_tag  <= in_tag;
         s2_p_rr <= PW'(s1_b_re) * PW'(s1_w_re);
         s2_p_ii <= PW'(s1_b_im) * PW'(s1_w_im);
         s2_p_ri <= PW'(s1_b_re) * PW'(s1_w_im);
         s2_p_ir <= PW'(s1_b_im) * PW'(s1_w_re);
         s2_a_re <= s1_a_re;
         s2_a_im <= s1_a_im;
         s2_tag  <= s1_tag;
         s3_x_re <= x_re_f[DATA_W-1:0];
         s3_x_im <= x_im_f[DATA_W-1:0];
         s3_y_re <= y_re_f[DATA_W-1:0];
         s3_y_im <= y_im_f[DATA_W-1:0];
         s3_tag  <= s2_tag;
      end
   end

   assign out_valid = s3_valid;
   assign out_x_re  = s3_x_re;
   assign out_x_im  = s3_x_im;
   assign out_y_re  = s3_y_re;
   assign out_y_im  = s3_y_im;
   assign out_tag   = s3_tag;
endmodule

// File: tb/tb_fft_butterfly_core.sv
// Bench for fft_butterfly_core: directed vectors, corner sequences and a scoreboarded random stream
// against a SCALE=1 and a SCALE=0 instance sharing the same input stream.
module tb_fft_butterfly_core;
   localparam int DW  = 16;
   localparam int TW  = 16;
   localparam int TGW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic areset, in_valid, out_ready, ovf_clr;
   logic [DW-1:0] a_re, a_im, b_re, b_im;
   logic [TW-1:0] w_re, w_im;
   logic [TGW-1:0] tag;
   logic rdy1, vld1, ovf1, rdy0, vld0, ovf0;
   logic [DW-1:0] x1_re, x1_im, y1_re, y1_im, x0_re, x0_im, y0_re, y0_im;
   logic [TGW-1:0] tag1, tag0;

   fft_butterfly_core #(.DATA_W(DW), .TW_W(TW), .SCALE(1), .TAG_W(TGW)) dut (
      .ACLK(clk), .ARESET(areset), .in_valid(in_valid), .in_ready(rdy1),
      .in_a_re(a_re), .in_a_im(a_im), .in_b_re(b_re), .in_b_im(b_im),
      .in_w_re(w_re), .in_w_im(w_im), .in_tag(tag),
      .out_valid(vld1), .out_ready(out_ready),
      .out_x_re(x1_re), .out_x_im(x1_im), .out_y_re(y1_re), .out_y_im(y1_im),
      .out_tag(tag1), .ovf(ovf1), .ovf_clr(ovf_clr));

   fft_butterfly_core #(.DATA_W(DW), .TW_W(TW), .SCALE(0), .TAG_W(TGW)) dut0 (
      .ACLK(clk), .ARESET(areset), .in_valid(in_valid), .in_ready(rdy0),
      .in_a_re(a_re), .in_a_im(a_im), .in_b_re(b_re), .in_b_im(b_im),
      .in_w_re(w_re), .in_w_im(w_im), .in_tag(tag),
      .out_valid(vld0), .out_ready(out_ready),
      .out_x_re(x0_re), .out_x_im(x0_im), .out_y_re(y0_re), .out_y_im(y0_im),
      .out_tag(tag0), .ovf(ovf0), .ovf_clr(ovf_clr));

   typedef struct packed {
      logic [15:0] xr, xi, yr, yi;
      logic [7:0]  tag;
   } res_t;

   typedef struct {
      string       name;
      logic [15:0] ar, ai, br, bi, wr, wi, xr, xi, yr, yi;
      bit          ovf;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic logic [15:0] fin(input longint v, input int scale);
      longint s;
      s = (scale != 0) ? ((v + 1) >>> 1) : v;
      if (s > 32767)  return 16'h7fff;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   // Reference butterfly in plain 64-bit integer arithmetic.
   function automatic res_t model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                  input logic [7:0] t, input int scale);
      res_t r;
      longint lar, lai, lbr, lbi, lwr, lwi, tr, ti, rnd;
      lar = longint'($signed(ar));
      lai = longint'($signed(ai));
      lbr = longint'($signed(br));
      lbi = longint'($signed(bi));
      lwr = longint'($signed(wr));
      lwi = longint'($signed(wi));
      rnd = longint'(1) <<< (TW - 2);
      tr  = (lbr * lwr - lbi * lwi + rnd) >>> (TW - 1);
      ti  = (lbr * lwi + lbi * lwr + rnd) >>> (TW - 1);
      r.xr  = fin(lar + tr, scale);
      r.xi  = fin(lai + ti, scale);
      r.yr  = fin(lar - tr, scale);
      r.yi  = fin(lai - ti, scale);
      r.tag = t;
      return r;
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'h7fff;
         default: return 16'($urandom);
      endcase
   endfunction

   // Presents one transfer and returns the number of cycles until out_valid.
   task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, input logic [7:0] t,
                       output int lat);
      a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi; tag = t;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!vld1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // mode 0: full rate, 1: 5-cycle stall at first output, 2: random valid/ready.
   task automatic run_stream(input int n, input int mode, input string nm);
      res_t q1[$];
      res_t q0[$];
      res_t e1, e0;
      logic [71:0] held;
      bit hold_prev = 0;
      int sent = 0, got = 0, cyc = 0, stall_cnt = 0;
      int first_in = -1, first_out = -1, last_out = -1;
      held = '0;
      while (got < n && cyc < 3000) begin
         if (hold_prev)
            chk({nm, "_stable"}, {vld1, x1_re, x1_im, y1_re, y1_im, tag1}, {1'b1, held});
         if (vld1 && first_out < 0) begin
            first_out = cyc;
            if (mode == 1) stall_cnt = 5;
         end
         if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
         else           out_ready = (stall_cnt == 0);
         if (stall_cnt > 0) stall_cnt--;
         in_valid = (sent < n) && (mode != 2 || $urandom_range(0, 2) != 0);
         a_re = rnd16(); a_im = rnd16(); b_re = rnd16(); b_im = rnd16();
         w_re = rnd16(); w_im = rnd16(); tag = 8'(sent);
         #1;
         if (mode == 1 && !out_ready && vld1) chk({nm, "_in_ready"}, rdy1, 1'b0);
         if (in_valid && rdy1) begin
            q1.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, tag, 1));
            q0.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, tag, 0));
            if (first_in < 0) first_in = cyc;
            sent++;
         end
         if (vld1 && out_ready) begin
            if (q1.size() == 0) chk({nm, "_extra_out"}, vld1, 1'b0);
            else begin
               e1 = q1.pop_front();
               e0 = q0.pop_front();
               chk({nm, "_scale1"}, {x1_re, x1_im, y1_re, y1_im, tag1}, e1);
               chk({nm, "_scale0"}, {x0_re, x0_im, y0_re, y0_im, tag0}, e0);
               got++;
               last_out = cyc;
            end
         end
         hold_prev = vld1 && !out_ready;
         held = {x1_re, x1_im, y1_re, y1_im, tag1};
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({nm, "_count"}, got, n);
      if (mode == 0) begin
         chk({nm, "_first_lat"}, first_out - first_in, 3);
         chk({nm, "_contig"}, last_out - first_out + 1, n);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run still active at %0t, required to end earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int lat, outs;
      vt[0] = '{"real_tw", 16'd1000, 16'd0, 16'd500, 16'd0, 16'h7fff, 16'h0000,
                16'd750, 16'd0, 16'd250, 16'd0, 1'b0};
      vt[1] = '{"neg_j", 16'd0, 16'd0, 16'd1000, 16'd2000, 16'h0000, 16'h8000,
                16'd1000, 16'hFE0C, 16'hFC18, 16'h01F4, 1'b0};
      vt[2] = '{"neg_one", 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h0000,
                16'h0000, 16'hC000, 16'h8000, 16'hC000, 1'b0};
      vt[3] = '{"sat_im", 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff,
                16'h4000, 16'h7fff, 16'h4000, 16'hC002, 1'b1};
      vt[4] = '{"round_neg", 16'hFFFD, 16'h0005, 16'hFFF9, 16'h0003, 16'h4000, 16'hC000,
                16'hFFFE, 16'h0005, 16'h0000, 16'h0000, 1'b0};

      areset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0; tag = '0;
      repeat (3) @(negedge clk);
      areset = 1'b0;
      #1;
      chk("reset_out_valid", {vld1, vld0}, 2'b00);
      chk("reset_ovf", {ovf1, ovf0}, 2'b00);
      chk("reset_in_ready", {rdy1, rdy0}, 2'b11);
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         send(vt[i].ar, vt[i].ai, vt[i].br, vt[i].bi, vt[i].wr, vt[i].wi, 8'(i), lat);
         chk({vt[i].name, "_latency"}, lat, 3);
         chk({vt[i].name, "_data"}, {x1_re, x1_im, y1_re, y1_im, tag1},
             {vt[i].xr, vt[i].xi, vt[i].yr, vt[i].yi, 8'(i)});
         chk({vt[i].name, "_ovf"}, ovf1, vt[i].ovf);
         ovf_clr = 1'b1;
         @(negedge clk);
         ovf_clr = 1'b0;
         @(negedge clk);
      end

      // Saturation without scaling, sticky flag, clear, and set-beats-clear.
      send(16'd30000, 16'd0, 16'd30000, 16'd0, 16'h7fff, 16'd0, 8'h33, lat);
      chk("sat_latency", lat, 3);
      chk("sat_data", {x0_re, x0_im, y0_re, y0_im, tag0}, {16'h7fff, 16'h0000, 16'h0001, 16'h0000, 8'h33});
      chk("sat_ovf_set", ovf0, 1'b1);
      repeat (3) @(negedge clk);
      chk("sat_ovf_held", ovf0, 1'b1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("sat_ovf_cleared", ovf0, 1'b0);
      ovf_clr = 1'b1;
      send(16'd30000, 16'd0, 16'd30000, 16'd0, 16'h7fff, 16'd0, 8'h34, lat);
      chk("ovf_set_wins", ovf0, 1'b1);
      @(negedge clk);
      chk("ovf_clr_after_set", ovf0, 1'b0);
      ovf_clr = 1'b0;
      repeat (4) @(negedge clk);

      run_stream(16, 0, "thru");
      repeat (4) @(negedge clk);
      run_stream(8, 1, "bp");
      repeat (4) @(negedge clk);
      run_stream(200, 2, "rand");
      repeat (4) @(negedge clk);

      // Reset with three transfers in flight and the flag set.
      send(vt[3].ar, vt[3].ai, vt[3].br, vt[3].bi, vt[3].wr, vt[3].wi, 8'h50, lat);
      chk("rst_pre_ovf", ovf1, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_re = rnd16(); a_im = rnd16(); b_re = rnd16(); b_im = rnd16();
         w_re = rnd16(); w_im = rnd16(); tag = 8'(8'hA1 + k);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rst_inflight", vld1, 1'b1);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      chk("rst_out_valid", {vld1, vld0}, 2'b00);
      chk("rst_ovf", {ovf1, ovf0}, 2'b00);
      out_ready = 1'b1;
      outs = 0;
      repeat (8) begin
         if (vld1 || vld0) outs++;
         @(negedge clk);
      end
      chk("rst_no_emit", outs, 0);
      send(vt[0].ar, vt[0].ai, vt[0].br, vt[0].bi, vt[0].wr, vt[0].wi, 8'h5A, lat);
      chk("rst_after_latency", lat, 3);
      chk("rst_after_data", {x1_re, x1_im, y1_re, y1_im, tag1},
          {vt[0].xr, vt[0].xi, vt[0].yr, vt[0].yi, 8'h5A});
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
